// File: rtl/fp32_pkg.sv
// fp32_pkg: constants, the divider FSM state type and IEEE-754 binary32
// operand classification helpers. The floating-point multiplier uses the
// same package.
// Contents:
//   QNAN, POS_INF           canonical special results
//   EXP_BIAS, EXP_MAX       exponent bias and all-ones exponent
//   FRAC_W, MANT_W, CNT_W   fraction, mantissa and iteration-counter widths
//   div_state_e             divider FSM states
//   is_zero/is_inf/is_nan   operand classification (denormals count as zero)
package fp32_pkg;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_INF  = 32'h7F800000;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam int          FRAC_W   = 23;
    localparam int          MANT_W   = FRAC_W + 1;
    localparam int          CNT_W    = 5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } div_state_e;

    // Denormals are flushed, so a zero exponent alone marks a zero operand.
    function automatic logic is_zero(input logic [7:0] e);
        return e == 8'h00;
    endfunction

    function automatic logic is_inf(input logic [7:0] e, input logic [FRAC_W-1:0] f);
        return (e == EXP_MAX) && (f == '0);
    endfunction

    function automatic logic is_nan(input logic [7:0] e, input logic [FRAC_W-1:0] f);
        return (e == EXP_MAX) && (f != '0);
    endfunction

endpackage

// File: rtl/bolucu_if.sv
// bolucu_if: request/response bundle of the floating-point divider.
// Signals:
//   start         request strobe, taken when the divider is idle
//   sayi1, sayi2  dividend and divisor, binary32
//   busy          iterative division in progress
//   done          one-cycle result strobe
//   sonuc         quotient, held until the next result or reset
// Modports: master drives the request, slave (the divider) answers.
interface bolucu_if;

    logic        start;
    logic [31:0] sayi1;
    logic [31:0] sayi2;
    logic        busy;
    logic        done;
    logic [31:0] sonuc;

    modport master (
        output start, sayi1, sayi2,
        input  busy, done, sonuc
    );

    modport slave (
        input  start, sayi1, sayi2,
        output busy, done, sonuc
    );

endinterface

// File: rtl/mantis_bolucu.sv
// mantis_bolucu: 24-bit restoring mantissa divider, one quotient bit per clock.
// The first bit is produced on the load edge itself, so 24 bits are complete
// 23 cycles after load and q_valid is raised for that cycle.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load         capture m1/m2 and produce the first quotient bit
//   m1, m2       normalised mantissas {1, frac}
//   q            quotient bits, MSB first; q[23] is the leading one
//   q_valid      all 24 bits of q are present
module mantis_bolucu
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [MANT_W-1:0] m1,
    input  logic [MANT_W-1:0] m2,
    output logic [MANT_W-1:0] q,
    output logic              q_valid
);

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MANT_W - 1);

    logic [MANT_W:0]   r_q, r_d;
    logic [MANT_W-1:0] q_q, q_d;
    logic [MANT_W-1:0] m2_q, m2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d;

    logic [MANT_W:0]   r_src;
    logic [MANT_W:0]   d_src;
    logic [MANT_W:0]   rem;
    logic              bit_now;

    always_comb begin
        // On the load edge the iteration works on the fresh operands directly.
        // A smaller dividend is pre-shifted so the first bit is always a one.
        r_src = r_q;
        d_src = {1'b0, m2_q};
        if (load) begin
            r_src = (m1 < m2) ? {m1, 1'b0} : {1'b0, m1};
            d_src = {1'b0, m2};
        end
        bit_now = (r_src >= d_src);
        rem     = bit_now ? (r_src - d_src) : r_src;

        r_d      = r_q;
        q_d      = q_q;
        m2_d     = m2_q;
        cnt_d    = cnt_q;
        active_d = active_q;

        if (load) begin
            r_d      = rem << 1;
            q_d      = {{(MANT_W-1){1'b0}}, bit_now};
            m2_d     = m2;
            cnt_d    = ITER_LAST;
            active_d = 1'b1;
        end else if (active_q && (cnt_q != '0)) begin
            r_d   = rem << 1;
            q_d   = {q_q[MANT_W-2:0], bit_now};
            cnt_d = cnt_q - 1'b1;
        end else if (active_q) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= '0;
            q_q      <= '0;
            m2_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            r_q      <= r_d;
            q_q      <= q_d;
            m2_q     <= m2_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign q       = q_q;
    assign q_valid = active_q && (cnt_q == '0);

endmodule

// File: rtl/bolucu.sv
// bolucu: sequential IEEE-754 binary32 divider, sonuc = sayi1 / sayi2.
// Special operands finish in one cycle; normal operands run a 24-step
// restoring mantissa division (busy for 24 cycles, done on the 25th).
// Result is truncated toward zero; denormals are flushed to zero.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset, aborts any division in flight
//   bus    bolucu_if slave: start/sayi1/sayi2 in, busy/done/sonuc out
//
// state  | meaning
// S_IDLE | waiting for start; special cases are answered from here
// S_DIV  | mantissa divider iterating, counter counts down to 0
module bolucu
    import fp32_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    bolucu_if.slave  bus
);

    localparam logic signed [9:0]  BIAS10    = 10'(EXP_BIAS);
    localparam logic signed [9:0]  EXP_OVF   = 10'sd255;
    localparam logic [CNT_W-1:0]   ITER_LAST = CNT_W'(MANT_W - 1);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       sonuc_q;
    logic              sign_q;
    logic signed [9:0] exp_q;

    logic [7:0]        e1, e2;
    logic [FRAC_W-1:0] f1, f2;
    logic [MANT_W-1:0] m1, m2;
    logic              sign_d;
    logic              adj;
    logic signed [9:0] exp_d;
    logic              spec_hit;
    logic [31:0]       spec_res;
    logic              load;
    logic [MANT_W-1:0] q;
    logic              q_valid;
    logic [31:0]       norm_res;

    always_comb begin
        e1     = bus.sayi1[30:23];
        e2     = bus.sayi2[30:23];
        f1     = bus.sayi1[FRAC_W-1:0];
        f2     = bus.sayi2[FRAC_W-1:0];
        m1     = {1'b1, f1};
        m2     = {1'b1, f2};
        sign_d = bus.sayi1[31] ^ bus.sayi2[31];
        adj    = (m1 < m2);
        exp_d  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS10
                 - $signed({9'd0, adj});

        // First match wins.
        spec_hit = 1'b1;
        spec_res = QNAN;
        if (is_nan(e1, f1) || is_nan(e2, f2)) begin
            spec_res = QNAN;
        end else if ((is_inf(e1, f1) && is_inf(e2, f2)) || (is_zero(e1) && is_zero(e2))) begin
            spec_res = QNAN;
        end else if (is_inf(e1, f1)) begin
            spec_res = {sign_d, POS_INF[30:0]};
        end else if (is_inf(e2, f2)) begin
            spec_res = {sign_d, 31'd0};
        end else if (is_zero(e2)) begin
            spec_res = {sign_d, POS_INF[30:0]};
        end else if (is_zero(e1)) begin
            spec_res = {sign_d, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end

        // q[23] is the hidden one; a quotient without it is not normalised
        // and is flushed rather than packed with a wrong exponent.
        if (exp_q >= EXP_OVF) begin
            norm_res = {sign_q, POS_INF[30:0]};
        end else if ((exp_q <= 10'sd0) || !q[MANT_W-1]) begin
            norm_res = {sign_q, 31'd0};
        end else begin
            norm_res = {sign_q, exp_q[7:0], q[FRAC_W-1:0]};
        end
    end

    assign load = (state_q == S_IDLE) && bus.start && !spec_hit;

    mantis_bolucu u_mantis (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .m1      (m1),
        .m2      (m2),
        .q       (q),
        .q_valid (q_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sonuc_q <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (spec_hit) begin
                            sonuc_q <= spec_res;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                            cnt_q   <= ITER_LAST;
                            sign_q  <= sign_d;
                            exp_q   <= exp_d;
                        end
                    end
                end
                S_DIV: begin
                    if ((cnt_q == '0) && q_valid) begin
                        sonuc_q <= norm_res;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sonuc = sonuc_q;

endmodule

// File: tb/tb_bolucu.sv
// tb_bolucu: table-driven bench for the binary32 divider with a result
// scoreboard, plus hand-written sequences for ignored start, reset abort
// and reset-versus-start priority.
module tb_bolucu;

    logic clk = 1'b0;
    logic reset;

    bolucu_if u_if ();

    bolucu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    localparam int NV = 17;
    vec_t        vecs [NV];
    logic [31:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Scoreboard: every done pops one expected quotient.
    always @(negedge clk) begin
        if (u_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: sonuc %h with no result outstanding", u_if.sonuc);
            end else begin
                chk("sonuc", u_if.sonuc, sb_q.pop_front());
            end
        end
    end

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        u_if.start = 1'b1;
        u_if.sayi1 = a;
        u_if.sayi2 = b;
        sb_q.push_back(res);
    endtask

    // Cycle k is the cycle after the k-th edge following the start edge.
    // inj_k > 0 raises start again in that cycle with other operands.
    task automatic wait_result(input string name, input int lat, input int inj_k,
                               input logic [31:0] inj_a, input logic [31:0] inj_b);
        int busy_n = 0;
        int seen   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (u_if.busy === 1'b1) busy_n++;
            if (u_if.done === 1'b1) begin
                seen = k;
                break;
            end
            if (k == inj_k) begin
                u_if.start = 1'b1;
                u_if.sayi1 = inj_a;
                u_if.sayi2 = inj_b;
            end else begin
                u_if.start = 1'b0;
                u_if.sayi1 = $urandom;
                u_if.sayi2 = $urandom;
            end
        end
        chk({name, " done_cycle"}, seen, lat);
        chk({name, " busy_cycles"}, busy_n, (lat == 25) ? 24 : 0);
    endtask

    initial begin
        reset      = 1'b1;
        u_if.start = 1'b0;
        u_if.sayi1 = '0;
        u_if.sayi2 = '0;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 25, "6/2"};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 25, "1/3"};
        vecs[2]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 25, "-6/2"};
        vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1,  "-1/0"};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1,  "0/0"};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1,  "nan/1"};
        vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 25, "overflow"};
        vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 25, "underflow"};
        vecs[8]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1,  "inf/inf"};
        vecs[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1,  "inf/-2"};
        vecs[10] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1,  "1/-inf"};
        vecs[11] = '{32'h00000000, 32'hC0000000, 32'h80000000, 1,  "0/-2"};
        vecs[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1,  "denorm/1"};
        vecs[13] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 1,  "1/denorm"};
        vecs[14] = '{32'h40490FDB, 32'h3F800000, 32'h40490FDB, 25, "pi/1"};
        vecs[15] = '{32'h3FC00000, 32'h3F400000, 32'h40000000, 25, "1.5/0.75"};
        vecs[16] = '{32'h41200000, 32'hC0A00000, 32'hC0000000, 25, "10/-5"};

        repeat (3) @(negedge clk);
        chk("reset sonuc", u_if.sonuc, 32'h0);
        chk("reset busy", {31'd0, u_if.busy}, 32'h0);
        chk("reset done", {31'd0, u_if.done}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Each vector is issued in the done cycle of the previous one.
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].res);
            wait_result(vecs[i].name, vecs[i].lat, 0, 32'h0, 32'h0);
        end
        u_if.start = 1'b0;
        @(negedge clk);
        chk("done width", {31'd0, u_if.done}, 32'h0);

        // A start while busy must be ignored.
        issue(32'h40C00000, 32'h40000000, 32'h40400000);
        wait_result("ignored_start", 25, 5, 32'h3F800000, 32'h40400000);
        u_if.start = 1'b0;
        @(negedge clk);
        chk("after ignored done", {31'd0, u_if.done}, 32'h0);
        chk("after ignored busy", {31'd0, u_if.busy}, 32'h0);

        // Reset in the middle of a division.
        issue(32'h40C00000, 32'h40000000, 32'h40400000);
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy before abort", {31'd0, u_if.busy}, 32'h1);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("abort busy", {31'd0, u_if.busy}, 32'h0);
        chk("abort done", {31'd0, u_if.done}, 32'h0);
        chk("abort sonuc", u_if.sonuc, 32'h0);
        reset = 1'b0;
        repeat (30) @(negedge clk);

        // Reset wins over a start in the same cycle.
        reset      = 1'b1;
        u_if.start = 1'b1;
        u_if.sayi1 = 32'h40C00000;
        u_if.sayi2 = 32'h40000000;
        @(negedge clk);
        reset      = 1'b0;
        u_if.start = 1'b0;
        chk("reset_vs_start busy", {31'd0, u_if.busy}, 32'h0);
        repeat (30) @(negedge clk);
        chk("reset_vs_start sonuc", u_if.sonuc, 32'h0);

        issue(32'h40C00000, 32'h40000000, 32'h40400000);
        wait_result("after_reset", 25, 0, 32'h0, 32'h0);
        u_if.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
